// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the multiplier sequencer
// state encoding. Used by alu, alu_mul_seq and the bench.
package alu_pkg;

    localparam int ALU_OP_W = 2;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 2'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LSL = 2'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 2'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_NOT = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Operand/result handshake plus the ALU borrow port of the multiplier
// sequencer. slave = sequencer side, master = CPU/ALU side.
interface alu_mul_seq_if #(
    parameter int REG_WIDTH    = 16,
    parameter int ALU_OP_WIDTH = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [REG_WIDTH-1:0]    in_a;
    logic [REG_WIDTH-1:0]    in_b;
    logic                    out_valid;
    logic                    out_ready;
    logic [REG_WIDTH-1:0]    out_prod;
    logic                    alu_sel;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [REG_WIDTH-1:0]    alu_rs;
    logic [REG_WIDTH-1:0]    alu_rt;
    logic [REG_WIDTH-1:0]    alu_result;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, alu_result,
        output in_ready, out_valid, out_prod, alu_sel, alu_op, alu_rs, alu_rt
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, alu_result,
        input  in_ready, out_valid, out_prod, alu_sel, alu_op, alu_rs, alu_rt
    );
endinterface

// File: rtl/alu.sv
// Single-cycle combinational ALU shared between the execute stage and the
// multiplier sequencer. LSL shifts rs left by rt, zero fill, wrapping.
module alu
    import alu_pkg::*;
#(
    parameter int REG_WIDTH    = 16,
    parameter int ALU_OP_WIDTH = 2
) (
    input  logic [ALU_OP_WIDTH-1:0] op_i,
    input  logic [REG_WIDTH-1:0]    rs_i,
    input  logic [REG_WIDTH-1:0]    rt_i,
    output logic [REG_WIDTH-1:0]    result_o
);

    // Opcode decode
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_OP_WIDTH'(ALU_OP_ADD): result_o = rs_i + rt_i;
            ALU_OP_WIDTH'(ALU_OP_LSL): result_o = rs_i << rt_i;
            ALU_OP_WIDTH'(ALU_OP_AND): result_o = rs_i & rt_i;
            ALU_OP_WIDTH'(ALU_OP_NOT): result_o = ~rs_i;
            default:                   result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer. Borrows the shared ALU for one ADD
// (STEP) and one LSL (SHIFT) per multiplier bit; returns the low REG_WIDTH
// product bits over a valid/ready port.
// Optional macro MUL_EARLY_EXIT_EN: leave the loop from STEP once no
// multiplier bits remain at or above the current position.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int REG_WIDTH    = 16,
    parameter int ALU_OP_WIDTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    alu_mul_seq_if.slave  bus
);

    localparam int CNT_W = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REG_WIDTH - 1);

    mul_state_t           state_q, state_d;
    logic [REG_WIDTH-1:0] mcand_q, mcand_d;
    logic [REG_WIDTH-1:0] mplier_q, mplier_d;
    logic [REG_WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // State and datapath registers; reset abandons any multiply in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: ALU result feeds prod in STEP and mcand in SHIFT
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = bus.in_a;
                    mplier_d = bus.in_b;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = STEP;
                end
            end
            STEP: begin
`ifdef MUL_EARLY_EXIT_EN
                // Nothing left to add: prod is already final
                if ((mplier_q >> cnt_q) == '0) begin
                    state_d = DONE;
                end else
`endif
                begin
                    if (mplier_q[cnt_q]) prod_d = bus.alu_result;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                mcand_d = bus.alu_result;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = STEP;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only; ALU driven idle-safe by default
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_prod  = '0;
        bus.alu_sel   = 1'b0;
        bus.alu_op    = ALU_OP_WIDTH'(ALU_OP_ADD);
        bus.alu_rs    = '0;
        bus.alu_rt    = '0;
        case (state_q)
            IDLE: bus.in_ready = 1'b1;
            STEP: begin
                bus.alu_sel = 1'b1;
                bus.alu_op  = ALU_OP_WIDTH'(ALU_OP_ADD);
                bus.alu_rs  = prod_q;
                bus.alu_rt  = mcand_q;
            end
            SHIFT: begin
                bus.alu_sel = 1'b1;
                bus.alu_op  = ALU_OP_WIDTH'(ALU_OP_LSL);
                bus.alu_rs  = mcand_q;
                bus.alu_rt  = REG_WIDTH'(1);
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_prod  = prod_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with the shared alu wired in.
// Expected latencies follow MUL_EARLY_EXIT_EN when it is defined.
module tb_alu_mul_seq;
    import alu_pkg::*;

    localparam int W   = 16;
    localparam int OPW = 2;

`ifdef MUL_EARLY_EXIT_EN
    localparam int L35 = 7,  LFF = 32, LZ = 1, L79 = 9, L44 = 7;
    localparam int L101 = 19, L2 = 5, RST_DLY = 3;
`else
    localparam int L35 = 32, LFF = 32, LZ = 32, L79 = 32, L44 = 32;
    localparam int L101 = 32, L2 = 32, RST_DLY = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_mul_seq_if #(.REG_WIDTH(W), .ALU_OP_WIDTH(OPW)) bus();

    alu_mul_seq #(.REG_WIDTH(W), .ALU_OP_WIDTH(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu #(.REG_WIDTH(W), .ALU_OP_WIDTH(OPW)) u_alu (
        .op_i     (bus.alu_op),
        .rs_i     (bus.alu_rs),
        .rt_i     (bus.alu_rt),
        .result_o (bus.alu_result)
    );

    // Reset-value checks on every output, then release
    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_prod !== 16'h0) begin errors++; $display("FAIL rst_out_prod got %h want 0", bus.out_prod); end
        checks++; if (bus.alu_sel !== 1'b0) begin errors++; $display("FAIL rst_alu_sel got %b want 0", bus.alu_sel); end
        checks++; if (bus.alu_op !== ALU_OP_ADD || bus.alu_rs !== 16'h0 || bus.alu_rt !== 16'h0) begin
            errors++; $display("FAIL rst_alu_drive got op=%0d rs=%h rt=%h want op=0 rs=0 rt=0", bus.alu_op, bus.alu_rs, bus.alu_rt);
        end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", bus.in_ready); end
    endtask

    // One multiply: accept, count edges to out_valid, check product,
    // and complete the handshake when out_ready is already high
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp, input int lat, input string name);
        int n;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready_before got %b want 1", name, bus.in_ready); end
        bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, n, lat); end
        checks++; if (bus.out_prod !== exp) begin errors++; $display("FAIL %s prod got %h want %h", name, bus.out_prod, exp); end
        if (bus.out_ready === 1'b1) begin
            @(posedge clk); #1;
            checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL %s after_hs got in_ready=%b out_valid=%b want 1/0", name, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        run_mul(16'd3, 16'd5, 16'd15, L35, "mul_3x5");
        run_mul(16'hFFFF, 16'hFFFF, 16'h0001, LFF, "mul_ffff_wrap");
        run_mul(16'h1234, 16'h0000, 16'h0000, LZ, "mul_b_zero");
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        run_mul(16'h00FF, 16'h0101, 16'hFFFF, L101, "b2b_ff_101");
        run_mul(16'h8000, 16'h0002, 16'h0000, L2, "b2b_shift_wrap");
        run_mul(16'hFFFD, 16'h0005, 16'hFFF1, L35, "b2b_neg3x5");
    endtask

    // Result held under back-pressure; new operands refused meanwhile
    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        run_mul(16'd7, 16'd9, 16'd63, L79, "bp_7x9");
        bus.in_valid = 1'b1; bus.in_a = 16'd1; bus.in_b = 16'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_prod !== 16'd63 || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc%0d got v=%b p=%0d r=%b want 1/63/0", i, bus.out_valid, bus.out_prod, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    // Asynchronous reset mid-multiply: no result ever appears
    task automatic test_reset_mid();
        logic seen;
        bus.out_ready = 1'b1;
        bus.in_a = 16'd2; bus.in_b = 16'd3; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (RST_DLY) begin @(posedge clk); #1; end
        checks++; if (bus.out_valid !== 1'b0 || bus.alu_sel !== 1'b1) begin
            errors++; $display("FAIL rmid_busy got out_valid=%b alu_sel=%b want 0/1", bus.out_valid, bus.alu_sel);
        end
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.alu_sel !== 1'b0 ||
                      bus.alu_op !== ALU_OP_ADD || bus.alu_rs !== 16'h0 || bus.alu_rt !== 16'h0 || bus.out_prod !== 16'h0) begin
            errors++; $display("FAIL rmid_outputs got r=%b v=%b sel=%b op=%0d rs=%h rt=%h p=%h want 1/0/0/0/0/0/0",
                               bus.in_ready, bus.out_valid, bus.alu_sel, bus.alu_op, bus.alu_rs, bus.alu_rt, bus.out_prod);
        end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_valid got out_valid seen=%b want 0", seen); end
        run_mul(16'd4, 16'd4, 16'd16, L44, "rmid_4x4");
    endtask

`ifndef MUL_EARLY_EXIT_EN
    // Cycle-by-cycle ALU borrow pattern for 1x1
    task automatic test_trace();
        logic [W-1:0] ers, ert;
        bus.out_ready = 1'b1;
        checks++; if (bus.alu_sel !== 1'b0) begin errors++; $display("FAIL trace_idle_sel got %b want 0", bus.alu_sel); end
        bus.in_a = 16'd1; bus.in_b = 16'd1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) begin
                ers = (i == 0) ? 16'd0 : 16'd1;
                ert = 16'd1 << (i / 2);
                checks++; if (bus.alu_sel !== 1'b1 || bus.alu_op !== ALU_OP_ADD || bus.alu_rs !== ers || bus.alu_rt !== ert) begin
                    errors++; $display("FAIL trace_step cyc%0d got sel=%b op=%0d rs=%h rt=%h want 1/0/%h/%h",
                                       i, bus.alu_sel, bus.alu_op, bus.alu_rs, bus.alu_rt, ers, ert);
                end
            end else begin
                ers = 16'd1 << (i / 2);
                checks++; if (bus.alu_sel !== 1'b1 || bus.alu_op !== ALU_OP_LSL || bus.alu_rs !== ers || bus.alu_rt !== 16'd1) begin
                    errors++; $display("FAIL trace_shift cyc%0d got sel=%b op=%0d rs=%h rt=%h want 1/1/%h/1",
                                       i, bus.alu_sel, bus.alu_op, bus.alu_rs, bus.alu_rt, ers);
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (bus.alu_sel !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_prod !== 16'd1) begin
            errors++; $display("FAIL trace_done got sel=%b v=%b p=%h want 0/1/1", bus.alu_sel, bus.out_valid, bus.out_prod);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifndef MUL_EARLY_EXIT_EN
        test_trace();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle multiplier sequencer that computes the low REG_WIDTH bits of a × b by time-sharing the single-cycle `alu` (ADD and LSL ops) through a shift-and-add loop. It sits beside the CPU execute stage. While busy it takes over the `alu` inputs through a top-level mux selected by `alu_sel`, and it returns the product over a valid/ready result port.

## Interface
- REG_WIDTH, default 16: operand, product and `alu` width.
- ALU_OP_WIDTH, default 2: width of the `alu` opcode.
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: operands valid.
- in_ready  out  1: block can accept operands. High only in IDLE.
- in_a  in  REG_WIDTH: multiplicand.
- in_b  in  REG_WIDTH: multiplier.
- out_valid  out  1: product valid. High only in DONE.
- out_ready  in  1: consumer accepts the product.
- out_prod  out  REG_WIDTH: low REG_WIDTH bits of a × b.
- alu_sel  out  1: block owns the `alu` this cycle. High in STEP and SHIFT.
- alu_op  out  ALU_OP_WIDTH: opcode driven to the `alu`.
- alu_rs, alu_rt  out  REG_WIDTH: `alu` operands.
- alu_result  in  REG_WIDTH: combinational `alu` result.

## Operation
- **Registers:**
  - mcand (REG_WIDTH)
  - mplier (REG_WIDTH)
  - prod (REG_WIDTH)
  - cnt ($clog2(REG_WIDTH) bits)
  - state
- **IDLE:**
  - Outputs: in_ready=1, alu_sel=0.
  - On in_valid: mcand←in_a, mplier←in_b, prod←0, cnt←0; go to STEP.
- **STEP:**
  - Drive alu_op=ADD, alu_rs=prod, alu_rt=mcand.
  - If mplier[cnt]=1, prod←alu_result; otherwise prod holds.
  - Go to SHIFT.
- **SHIFT:**
  - Drive alu_op=LSL, alu_rs=mcand, alu_rt=1.
  - mcand←alu_result.
  - If cnt=REG_WIDTH-1, go to DONE; otherwise cnt←cnt+1 and go to STEP.
- **DONE:**
  - Outputs: out_valid=1, out_prod=prod.
  - On out_ready, go to IDLE.
  - New operands are not accepted in the same cycle as the result handshake.
- **Idle drive values:** when alu_sel=0, alu_op=ADD and alu_rs=alu_rt=0.
- **Arithmetic:** all adds and shifts wrap modulo 2^REG_WIDTH. The low product bits are identical for signed and unsigned operands, so no sign handling is needed.
- **Reset values:** state=IDLE; prod, mcand, mplier and cnt = 0.
  - Outputs under reset: in_ready=1, out_valid=0, out_prod=0, alu_sel=0, alu_op=ADD, alu_rs=0, alu_rt=0.
- **Reset mid-operation:** immediately abandons the computation. No out_valid is ever produced for the abandoned operands.
- **in_valid outside IDLE:** ignored; in_ready=0 there.
- **Back-pressure in DONE:** out_prod and out_valid are held stable for as long as out_ready=0.

## Timing
- **Acceptance:** operands are accepted on an edge where in_valid & in_ready.
- **Latency without early exit:** out_valid is first high 2·REG_WIDTH edges after the accept edge (32 for REG_WIDTH=16).
- **ALU path:** the `alu` is combinational inside the loop, so every STEP and SHIFT completes in exactly one cycle.
- **Throughput:** one multiply per 2·REG_WIDTH+2 cycles when out_ready is held high.
- **Output timing:** all outputs are registered-state decodes. No output has a combinational path from in_valid or out_ready.

## Configuration
- **Macro:** MUL_EARLY_EXIT_EN.
- **Defined:** in STEP, if (mplier >> cnt) == 0, go directly to DONE.
  - prod is not updated in that cycle.
  - Latency becomes 2·k+1 edges, where k = index of the highest set bit of in_b, plus one.
  - For in_b=0, latency is 1 edge.
- **Undefined:** latency is fixed at 2·REG_WIDTH for every operand pair.

## Structure
- **Shared package `alu_pkg`:**
  - ALU opcode constants ALU_OP_ADD, ALU_OP_LSL, ALU_OP_AND, ALU_OP_NOT.
  - Typedef `mul_state_t` enum {IDLE, STEP, SHIFT, DONE}.
- **Sub-modules:** none inside this block.
  - The `alu` instance and the alu_sel mux live at the top level.
  - The bench instantiates the existing `alu` and wires it to alu_op/alu_rs/alu_rt/alu_result.

## Test plan
- in_a=3, in_b=5, out_ready=1:
  - out_prod=15 in all builds.
  - out_valid 32 edges after accept without the macro; 7 edges after with MUL_EARLY_EXIT_EN.
- in_a=0xFFFF, in_b=0xFFFF → out_prod=0x0001 (wrap); latency 32 edges in both builds.
- in_a=0x1234, in_b=0 → out_prod=0; 32 edges without the macro, 1 edge with it.
- in_a=7, in_b=9, out_ready=0 for 10 cycles after out_valid:
  - out_prod=63 held stable; in_ready=0 throughout.
  - After out_ready=1: in_ready=1 on the next cycle.
- rst asserted 5 cycles after accepting in_a=2, in_b=3:
  - All outputs return to reset values immediately; no out_valid is produced.
  - A following 4×4 multiply returns 16.
- Trace alu_sel/alu_op on 1×1 (no macro):
  - alternating ADD, LSL with alu_rt=1 in SHIFT, for 32 cycles.
  - alu_sel=0 in IDLE and DONE.
